mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage of the five-stage CPU, placed between execute and writeback. Holds one instruction at a time, drives a request/addr_ok/data_ok data-memory interface for loads and stores, aligns and sign/zero-extends load data, and presents a registered bundle to the writeback stage. It supplies the writeback stage's MemtoReg/RegWrite/Aluout/rdata/rd/mfc0/except_data inputs.

## Interface
Parameters:
- none; all widths are fixed at 32-bit data/address and 5-bit register index.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- ex_valid  in  1  execute stage offers an instruction
- mem_allow_in  out  1  stage accepts the offered instruction this cycle
- ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_mfc0  in  1 each  control bits from execute
- ex_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- ex_sign  in  1  load sign-extends when 1
- ex_aluout  in  32  effective address, or ALU result for non-memory instructions
- ex_wdata  in  32  store data from rt
- ex_rd  in  5  destination register
- ex_except_data  in  32  CP0 read value
- data_req, data_wr  out  1  memory request; write when data_wr=1
- data_be  out  4  byte enables
- data_addr, data_wdata  out  32  word-aligned address and store data
- data_addr_ok, data_data_ok  in  1  request accepted; response or write-complete
- data_rdata  in  32  load data, valid with data_data_ok
- wb_valid  out  1  bundle to writeback is valid
- wb_allow_in  in  1  writeback consumes the bundle
- MemtoReg, RegWrite, mfc0  out  1  registered controls to writeback
- Aluout, rdata, except_data  out  32  registered data to writeback; rdata is already extended
- rd  out  5  registered destination register

## Operation
- States: IDLE, REQ, WAIT, DONE.
- Accept condition: ex_valid && mem_allow_in.
  - On accept, latch all ex_* fields.
  - Go to REQ if memread|memwrite, else go to DONE.
- mem_allow_in = (state==IDLE) || (state==DONE && wb_allow_in).
  - A new instruction may be accepted in the same cycle the current bundle leaves, giving back-to-back issue.
- REQ state:
  - data_req=1 and address/data/be are held stable.
  - On data_addr_ok, go to WAIT.
- WAIT state:
  - data_req=0.
  - On data_data_ok: a load captures the extended data into rdata, a store captures nothing; then go to DONE.
- data_data_ok is ignored in IDLE, REQ and DONE. The memory never returns data_ok in the same cycle as addr_ok.
- DONE state:
  - wb_valid=1.
  - On wb_allow_in, go to IDLE, or to REQ/DONE when a new instruction is accepted in the same cycle.
- Byte enables, where off = addr[1:0]:
  - byte: be = 0001<<off, wdata = byte replicated ×4
  - half: be = 0011<<(off&2), wdata = half replicated ×2
  - word: be = 1111
- data_addr = {addr[31:2],2'b00}.
- Load extraction:
  - byte lane = off; half lane = off[1].
  - Extend to 32 bits per ex_sign.
  - Word loads pass data_rdata through unchanged.
- Aluout, rd, mfc0, except_data, MemtoReg and RegWrite pass unchanged from the latch.
- Reset (any cycle, including REQ/WAIT): state=IDLE. All outputs go to 0 except mem_allow_in=1. A data_ok that arrives after reset is ignored.

## Timing
- Non-memory instruction: accepted at edge T0, wb_valid high after T0.
- Memory instruction:
  - data_req is high from the edge after accept.
  - wb_valid rises the edge after data_data_ok.
  - Minimum latency is 3 cycles from accept to wb_valid.
- Outputs to writeback change only on leaving DONE or entering DONE. They are stable while wb_valid && !wb_allow_in.

## Configuration
- MEM_ALIGN_EXC_EN defined:
  - Detect misalignment: a half access with addr[0]=1, or a word access with addr[1:0]≠0.
  - On a misaligned access, skip REQ and go straight to DONE with RegWrite=0 and MemtoReg=0.
  - Assert adel (load) or ades (store) and set badvaddr = full unaligned address.
  - These add ports adel out 1, ades out 1 and badvaddr out 32, all reset to 0.
- MEM_ALIGN_EXC_EN undefined: those ports are absent, the low address bits are silently masked per size, and the access proceeds.

## Structure
- Package mem_pkg contains:
  - state enum (IDLE/REQ/WAIT/DONE)
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - byte-enable and store-replication functions
- Sub-module mem_load_ext is combinational: data_rdata, off, size and sign in; extended 32-bit result out.

## Test plan
- ALU op with ex_aluout=0x1234, rd=5, regwrite=1, wb_allow_in=1 -> wb_valid after 1 cycle with Aluout=0x1234, rd=5, RegWrite=1, no data_req.
- LB, sign=1, addr=0x1003, data_rdata=0x80FF_FF7F -> rdata=0xFFFF_FF80. Same case with LBU -> rdata=0x0000_0080.
- SH at addr=0x2002 with wdata=0xABCD -> data_addr=0x2000, be=1100, data_wdata=0xABCD_ABCD, data_wr=1. With addr_ok delayed 3 cycles, data_req holds its value throughout.
- wb_allow_in=0 for 4 cycles in DONE -> bundle held, mem_allow_in=0. Raising wb_allow_in together with ex_valid -> next instruction accepted in the same cycle.
- reset asserted in WAIT, then data_data_ok pulses -> state IDLE, wb_valid=0, rdata=0.
- With MEM_ALIGN_EXC_EN: LW at 0x1002 -> no data_req, adel=1, badvaddr=0x1002, RegWrite=0 after 1 cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared state, size encodings, writeback bundle and store helpers for mem_stage.
package mem_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   typedef struct packed {
      logic        memtoreg;
      logic        regwrite;
      logic        mfc0;
      logic [31:0] aluout;
      logic [31:0] except_data;
      logic [4:0]  rd;
   } wb_bundle_t;
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << (off & 2'b10) : 4'b1111;
   endfunction
   function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] data);
      return size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
   endfunction
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return (size == SZ_HALF && off[0]) || (size >= SZ_WORD && off != 2'b00);
   endfunction
endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: selects the addressed byte/half lane of load data and extends it to 32 bits.
module mem_load_ext
   import mem_pkg::*;
(
   input  logic [31:0] data_rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] result
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = data_rdata[{off, 3'b000} +: 8];
      h = data_rdata[{off[1], 4'b0000} +: 16];
      result = size == SZ_BYTE ? {{24{sign & b[7]}}, b} : size == SZ_HALF ? {{16{sign & h[15]}}, h} : data_rdata;
   end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with request/addr_ok/data_ok data port.
// Define MEM_ALIGN_EXC_EN to trap misaligned accesses (adds adel/ades/badvaddr ports).
module mem_stage
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   output logic        mem_allow_in,
   input  logic        ex_memread,
   input  logic        ex_memwrite,
   input  logic        ex_memtoreg,
   input  logic        ex_regwrite,
   input  logic        ex_mfc0,
   input  logic [1:0]  ex_size,
   input  logic        ex_sign,
   input  logic [31:0] ex_aluout,
   input  logic [31:0] ex_wdata,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_except_data,
   output logic        data_req,
   output logic        data_wr,
   output logic [3:0]  data_be,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        wb_valid,
   input  logic        wb_allow_in,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        mfc0,
   output logic [31:0] Aluout,
   output logic [31:0] rdata,
   output logic [31:0] except_data,
`ifdef MEM_ALIGN_EXC_EN
   output logic        adel,
   output logic        ades,
   output logic [31:0] badvaddr,
`endif
   output logic [4:0]  rd
);
   state_t     state, next_state;
   wb_bundle_t ex_b, l_b, wb;
   logic       l_memread, l_memwrite, l_sign;
   logic [1:0] l_size;
   logic [31:0] l_wdata, ext;
   logic       mem_ex, mis_ex, accept, enter_done;

   assign mem_ex = ex_memread | ex_memwrite;
`ifdef MEM_ALIGN_EXC_EN
   assign mis_ex = mem_ex && misaligned(ex_size, ex_aluout[1:0]);
`else
   assign mis_ex = 1'b0;
`endif
   assign accept = ex_valid && mem_allow_in;
   // writeback outputs load only here, so they stay frozen while DONE stalls
   assign enter_done = (accept && !(mem_ex && !mis_ex)) || (state == WAIT && data_data_ok);
   assign ex_b = '{memtoreg: ex_memtoreg & ~mis_ex, regwrite: ex_regwrite & ~mis_ex, mfc0: ex_mfc0,
                   aluout: ex_aluout, except_data: ex_except_data, rd: ex_rd};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= next_state;
   end

   always_comb begin
      next_state = accept ? ((mem_ex && !mis_ex) ? REQ : DONE) :
                   (state == REQ && data_addr_ok) ? WAIT :
                   (state == WAIT && data_data_ok) ? DONE :
                   (state == DONE && wb_allow_in) ? IDLE : state;
   end

   always_comb begin
      mem_allow_in = state == IDLE || (state == DONE && wb_allow_in);
      data_req = state == REQ;
      data_wr = data_req & l_memwrite;
      data_be = data_req ? byte_en(l_size, l_b.aluout[1:0]) : 4'b0000;
      wb_valid = state == DONE;
   end

   assign data_addr = {l_b.aluout[31:2], 2'b00};
   assign data_wdata = store_rep(l_size, l_wdata);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_b <= '0;
         l_memread <= 1'b0;
         l_memwrite <= 1'b0;
         l_sign <= 1'b0;
         l_size <= 2'b00;
         l_wdata <= '0;
      end else if (accept) begin
         l_b <= ex_b;
         l_memread <= ex_memread;
         l_memwrite <= ex_memwrite;
         l_sign <= ex_sign;
         l_size <= ex_size;
         l_wdata <= ex_wdata;
      end
   end

   mem_load_ext u_ext (
      .data_rdata(data_rdata),
      .off       (l_b.aluout[1:0]),
      .size      (l_size),
      .sign      (l_sign),
      .result    (ext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb <= '0;
         rdata <= '0;
      end else if (enter_done) begin
         wb <= accept ? ex_b : l_b;
         if (!accept && l_memread) rdata <= ext;
      end
   end

`ifdef MEM_ALIGN_EXC_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adel <= 1'b0;
         ades <= 1'b0;
         badvaddr <= '0;
      end else if (enter_done) begin
         adel <= accept && mis_ex && ex_memread;
         ades <= accept && mis_ex && ex_memwrite;
         badvaddr <= (accept && mis_ex) ? ex_aluout : 32'h0;
      end
   end
`endif

   assign MemtoReg = wb.memtoreg;
   assign RegWrite = wb.regwrite;
   assign mfc0 = wb.mfc0;
   assign Aluout = wb.aluout;
   assign except_data = wb.except_data;
   assign rd = wb.rd;
endmodule
